// File: rtl/wb_exc_commit_pkg.sv
// Shared constants for the write-back exception commit stage and the CSR file:
// exception codes, mem_exc bit positions, CSR numbers and FSM/tag types.
package wb_exc_commit_pkg;

  // Exception codes driven to the CSR file (ESTAT.Ecode / EsubCode)
  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;

  localparam logic [8:0] ESUBCODE_ADEF = 9'd0;
  localparam logic [8:0] ESUBCODE_NONE = 9'd0;

  // Bit positions inside mem_exc {ale, brk, sys, ine, adef}
  localparam int EXC_ADEF = 0;
  localparam int EXC_INE  = 1;
  localparam int EXC_SYS  = 2;
  localparam int EXC_BRK  = 3;
  localparam int EXC_ALE  = 4;

  // CSR numbers shared with the CSR file
  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_EENTRY = 14'h00C;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_SAVE1  = 14'h031;
  localparam logic [13:0] CSR_SAVE2  = 14'h032;
  localparam logic [13:0] CSR_SAVE3  = 14'h033;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  // Commit FSM: RUN accepts MEM, DRAIN discards MEM after a redirect
  typedef enum logic {
    S_RUN   = 1'b0,
    S_DRAIN = 1'b1
  } wb_state_e;

  // Exception tags of the instruction currently in WB, already qualified by valid
  typedef struct packed {
    logic intr;
    logic adef;
    logic ine;
    logic sys;
    logic brk;
    logic ale;
  } exc_tags_t;

  // Builds the tag vector; every tag is forced low for a bubble so that
  // neither an interrupt nor a stale exception flag can fire on an invalid slot.
  function automatic exc_tags_t make_tags(input logic valid, input logic has_int,
                                          input logic [4:0] exc);
    exc_tags_t t;
    t.intr = valid & has_int;
    t.adef = valid & exc[EXC_ADEF];
    t.ine  = valid & exc[EXC_INE];
    t.sys  = valid & exc[EXC_SYS];
    t.brk  = valid & exc[EXC_BRK];
    t.ale  = valid & exc[EXC_ALE];
    return t;
  endfunction

endpackage

// File: rtl/wb_exc_commit_exc_prio_enc.sv
// Fixed-priority exception encoder: INT > ADEF > INE > SYS > BRK > ALE.
// Purely combinational; reports the winning cause and whether it was ADEF/ALE
// so the caller can pick the bad virtual address.
module exc_prio_enc
  import wb_exc_commit_pkg::*;
(
  input  exc_tags_t  tags_i,
  output logic       ex_o,
  output logic [5:0] ecode_o,
  output logic [8:0] esubcode_o,
  output logic       is_adef_o,
  output logic       is_ale_o
);

  // Select the highest-priority pending cause
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    ex_o       = 1'b1;
    ecode_o    = ECODE_INT;
    esubcode_o = ESUBCODE_NONE;
    is_adef_o  = 1'b0;
    is_ale_o   = 1'b0;
    if (tags_i.intr) begin
      ecode_o = ECODE_INT;
    end else if (tags_i.adef) begin
      ecode_o    = ECODE_ADEF;
      esubcode_o = ESUBCODE_ADEF;
      is_adef_o  = 1'b1;
    end else if (tags_i.ine) begin
      ecode_o = ECODE_INE;
    end else if (tags_i.sys) begin
      ecode_o = ECODE_SYS;
    end else if (tags_i.brk) begin
      ecode_o = ECODE_BRK;
    end else if (tags_i.ale) begin
      ecode_o  = ECODE_ALE;
      is_ale_o = 1'b1;
    end else begin
      ex_o = 1'b0;
    end
  end

endmodule

// File: rtl/wb_exc_commit.sv
// Write-back stage with exception/ertn commit. Holds one WB register, encodes
// exceptions with zero latency, suppresses side-effects of excepting
// instructions and drains the MEM stage for FLUSH_DRAIN cycles after a redirect.
// Optional trace outputs are enabled by defining WB_TRACE_EN.
module wb_exc_commit
  import wb_exc_commit_pkg::*;
#(
  parameter int FLUSH_DRAIN = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic [4:0]  mem_exc,
  input  logic [31:0] mem_badv,
  input  logic        mem_ertn,
  input  logic        mem_csr_we,
  input  logic [13:0] mem_csr_num,
  input  logic [31:0] mem_csr_wmask,
  input  logic [31:0] mem_csr_wvalue,
  input  logic        mem_rf_we,
  input  logic [4:0]  mem_rf_waddr,
  input  logic [31:0] mem_rf_wdata,
  input  logic        csr_has_int,
  output logic        wb_allowin,
  output logic        wb_ex,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] WB_pc,
  output logic [31:0] wb_badvaddr,
  output logic        ertn_flush,
  output logic        csr_we,
  output logic [13:0] csr_num,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wvalue,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        flush_req,
  output logic        flush_sel
`ifdef WB_TRACE_EN
  ,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_we,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
`endif
);

  localparam logic [2:0] DRAIN_INIT = 3'(FLUSH_DRAIN);

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  exc;
    logic [31:0] badv;
    logic        ertn;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } wb_reg_t;

  wb_state_e  state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       wb_valid_q, wb_valid_d;
  wb_reg_t    wb_q;
  logic       wb_load;
  exc_tags_t  tags;
  logic       is_adef, is_ale;

  assign wb_allowin = (state_q == S_RUN);
  assign wb_load    = mem_valid & wb_allowin & ~flush_req;
  assign wb_valid_d = wb_load;

  // Valid bit: cleared by reset and by any redirect, otherwise follows MEM handshake
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!resetn) begin
      wb_valid_q <= 1'b0;
    end else begin
      wb_valid_q <= wb_valid_d;
    end
  end

  // WB payload register; only loaded with a live instruction
  always_ff @(posedge clk) begin
    // NOTE: payload has no reset; every consumer is qualified by wb_valid_q.
    if (wb_load) begin
      wb_q <= '{pc: mem_pc, exc: mem_exc, badv: mem_badv, ertn: mem_ertn,
                csr_we: mem_csr_we, csr_num: mem_csr_num, csr_wmask: mem_csr_wmask,
                csr_wvalue: mem_csr_wvalue, rf_we: mem_rf_we,
                rf_waddr: mem_rf_waddr, rf_wdata: mem_rf_wdata};
    end
  end

  // Exception tagging and priority encoding of the WB instruction
  assign tags = make_tags(wb_valid_q, csr_has_int, wb_q.exc);

  exc_prio_enc u_prio (
    .tags_i     (tags),
    .ex_o       (wb_ex),
    .ecode_o    (wb_ecode),
    .esubcode_o (wb_esubcode),
    .is_adef_o  (is_adef),
    .is_ale_o   (is_ale)
  );

  // Bad address: PC for fetch faults, latched data address for misalignment
  always_comb begin
    wb_badvaddr = 32'h0;
    if (is_adef) begin
      wb_badvaddr = wb_q.pc;
    end else if (is_ale) begin
      wb_badvaddr = wb_q.badv;
    end
  end

  // Commit strobes, suppressed when the instruction takes an exception
  assign ertn_flush = wb_valid_q & wb_q.ertn   & ~wb_ex;
  assign csr_we     = wb_valid_q & wb_q.csr_we & ~wb_ex;
  assign rf_we      = wb_valid_q & wb_q.rf_we  & ~wb_ex;
  assign flush_req  = wb_ex | ertn_flush;
  assign flush_sel  = ertn_flush;

  assign WB_pc      = wb_q.pc;
  assign csr_num    = wb_q.csr_num;
  assign csr_wmask  = wb_q.csr_wmask;
  assign csr_wvalue = wb_q.csr_wvalue;
  assign rf_waddr   = wb_q.rf_waddr;
  assign rf_wdata   = wb_q.rf_wdata;

  // Drain FSM state and counter register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Drain FSM next state: count FLUSH_DRAIN cycles of discarded MEM input
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_RUN: begin
        if (flush_req) begin
          state_d = S_DRAIN;
          cnt_d   = DRAIN_INIT;
        end
      end
      S_DRAIN: begin
        if (cnt_q <= 3'd1) begin
          state_d = S_RUN;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = S_RUN;
        cnt_d   = 3'd0;
      end
    endcase
  end

`ifdef WB_TRACE_EN
  // Trace port for the reference-model comparator
  assign debug_wb_pc       = wb_q.pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = wb_q.rf_waddr;
  assign debug_wb_rf_wdata = wb_q.rf_wdata;
`endif

endmodule

// File: tb/tb_wb_exc_commit.sv
// Directed bench for wb_exc_commit: exception priority, badv selection,
// side-effect suppression, ertn drain length, back-to-back commits and
// reset during DRAIN.
module tb_wb_exc_commit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic [4:0]  mem_exc;
  logic [31:0] mem_badv;
  logic        mem_ertn;
  logic        mem_csr_we;
  logic [13:0] mem_csr_num;
  logic [31:0] mem_csr_wmask;
  logic [31:0] mem_csr_wvalue;
  logic        mem_rf_we;
  logic [4:0]  mem_rf_waddr;
  logic [31:0] mem_rf_wdata;
  logic        csr_has_int;
  logic        wb_allowin;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] WB_pc;
  logic [31:0] wb_badvaddr;
  logic        ertn_flush;
  logic        csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        flush_req;
  logic        flush_sel;
`ifdef WB_TRACE_EN
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
`endif

  int checks = 0;
  int errors = 0;

  wb_exc_commit #(.FLUSH_DRAIN(2)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .mem_valid      (mem_valid),
    .mem_pc         (mem_pc),
    .mem_exc        (mem_exc),
    .mem_badv       (mem_badv),
    .mem_ertn       (mem_ertn),
    .mem_csr_we     (mem_csr_we),
    .mem_csr_num    (mem_csr_num),
    .mem_csr_wmask  (mem_csr_wmask),
    .mem_csr_wvalue (mem_csr_wvalue),
    .mem_rf_we      (mem_rf_we),
    .mem_rf_waddr   (mem_rf_waddr),
    .mem_rf_wdata   (mem_rf_wdata),
    .csr_has_int    (csr_has_int),
    .wb_allowin     (wb_allowin),
    .wb_ex          (wb_ex),
    .wb_ecode       (wb_ecode),
    .wb_esubcode    (wb_esubcode),
    .WB_pc          (WB_pc),
    .wb_badvaddr    (wb_badvaddr),
    .ertn_flush     (ertn_flush),
    .csr_we         (csr_we),
    .csr_num        (csr_num),
    .csr_wmask      (csr_wmask),
    .csr_wvalue     (csr_wvalue),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .flush_req      (flush_req),
    .flush_sel      (flush_sel)
`ifdef WB_TRACE_EN
    ,
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one cycle and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    mem_valid      = 1'b0;
    mem_pc         = 32'h0;
    mem_exc        = 5'b0;
    mem_badv       = 32'h0;
    mem_ertn       = 1'b0;
    mem_csr_we     = 1'b0;
    mem_csr_num    = 14'h0;
    mem_csr_wmask  = 32'h0;
    mem_csr_wvalue = 32'h0;
    mem_rf_we      = 1'b0;
    mem_rf_waddr   = 5'h0;
    mem_rf_wdata   = 32'h0;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [4:0] exc, input logic [31:0] badv,
                       input logic ertn, input logic cwe, input logic [13:0] cnum,
                       input logic [31:0] cval, input logic rwe, input logic [4:0] raddr,
                       input logic [31:0] rdata);
    mem_valid      = 1'b1;
    mem_pc         = pc;
    mem_exc        = exc;
    mem_badv       = badv;
    mem_ertn       = ertn;
    mem_csr_we     = cwe;
    mem_csr_num    = cnum;
    mem_csr_wmask  = 32'hFFFF_FFFF;
    mem_csr_wvalue = cval;
    mem_rf_we      = rwe;
    mem_rf_waddr   = raddr;
    mem_rf_wdata   = rdata;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int stall_cycles;
    int leaked;
    resetn      = 1'b0;
    csr_has_int = 1'b0;
    clear_mem();
    tick();
    tick();
    resetn = 1'b1;

    // Reset state
    check("rst_allowin", 32'(wb_allowin), 32'd1);
    check("rst_wb_ex",   32'(wb_ex),      32'd0);
    check("rst_ertn",    32'(ertn_flush), 32'd0);
    check("rst_csr_we",  32'(csr_we),     32'd0);
    check("rst_rf_we",   32'(rf_we),      32'd0);
    check("rst_flush",   32'(flush_req),  32'd0);

    // ADEF: badv is the PC, redirect to the exception entry
    drive(32'h1C00_0004, 5'b00001, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0, 1'b0, 5'h0, 32'h0);
    tick();
    clear_mem();
    check("adef_ex",    32'(wb_ex),       32'd1);
    check("adef_ecode", 32'(wb_ecode),    32'h08);
    check("adef_esub",  32'(wb_esubcode), 32'h0);
    check("adef_badv",  wb_badvaddr,      32'h1C00_0004);
    check("adef_pc",    WB_pc,            32'h1C00_0004);
    check("adef_flush", 32'(flush_req),   32'd1);
    check("adef_sel",   32'(flush_sel),   32'd0);
    tick();
    check("adef_drain_allowin", 32'(wb_allowin), 32'd0);
    check("adef_drain_ex",      32'(wb_ex),      32'd0);
    tick();
    tick();
    check("adef_back_run", 32'(wb_allowin), 32'd1);

    // ALE with a GPR write: badv from MEM, write suppressed
    drive(32'h1C00_0100, 5'b10000, 32'h0000_0123, 1'b0, 1'b0, 14'h0, 32'h0,
          1'b1, 5'd5, 32'hDEAD_BEEF);
    tick();
    clear_mem();
    check("ale_ex",    32'(wb_ex),    32'd1);
    check("ale_ecode", 32'(wb_ecode), 32'h09);
    check("ale_badv",  wb_badvaddr,   32'h0000_0123);
    check("ale_rf_we", 32'(rf_we),    32'd0);
    tick();
    tick();
    tick();

    // SYS+BRK with a pending interrupt: interrupt wins, then SYS beats BRK
    drive(32'h1C00_0200, 5'b01100, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0, 1'b0, 5'h0, 32'h0);
    tick();
    clear_mem();
    csr_has_int = 1'b1;
    #1;
    check("int_ex",    32'(wb_ex),     32'd1);
    check("int_ecode", 32'(wb_ecode),  32'h00);
    check("int_badv",  wb_badvaddr,    32'h0);
    csr_has_int = 1'b0;
    #1;
    check("sys_ecode", 32'(wb_ecode),  32'h0B);
    check("sys_flush", 32'(flush_req), 32'd1);
    tick();
    tick();
    tick();

    // Interrupt on a bubble is not taken
    csr_has_int = 1'b1;
    #1;
    check("int_bubble_ex", 32'(wb_ex), 32'd0);
    csr_has_int = 1'b0;

    // ertn: exit redirect, following MEM instructions discarded for the drain
    drive(32'h1C00_0300, 5'b0, 32'h0, 1'b1, 1'b0, 14'h0, 32'h0, 1'b0, 5'h0, 32'h0);
    tick();
    drive(32'h1C00_0304, 5'b0, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0, 1'b1, 5'd7, 32'h0000_0077);
    check("ertn_flush", 32'(ertn_flush), 32'd1);
    check("ertn_sel",   32'(flush_sel),  32'd1);
    check("ertn_req",   32'(flush_req),  32'd1);
    check("ertn_ex",    32'(wb_ex),      32'd0);
    stall_cycles = 0;
    leaked       = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rf_we) leaked++;
      if (!wb_allowin) stall_cycles++;
    end
    check("ertn_no_commit",  32'(leaked),       32'd0);
    check("ertn_stall_len",  32'(stall_cycles), 32'd2);
    tick();
    clear_mem();
    check("ertn_resume_rf_we", 32'(rf_we),    32'd1);
    check("ertn_resume_waddr", 32'(rf_waddr), 32'd7);
    tick();

    // Back-to-back csrwr SAVE0 then add
    drive(32'h1C00_0400, 5'b0, 32'h0, 1'b0, 1'b1, 14'h030, 32'h0000_CAFE,
          1'b0, 5'h0, 32'h0);
    tick();
    drive(32'h1C00_0404, 5'b0, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0, 1'b1, 5'd3, 32'h0000_0055);
    check("csrwr_we",    32'(csr_we),    32'd1);
    check("csrwr_num",   32'(csr_num),   32'h030);
    check("csrwr_val",   csr_wvalue,     32'h0000_CAFE);
    check("csrwr_mask",  csr_wmask,      32'hFFFF_FFFF);
    check("csrwr_rf_we", 32'(rf_we),     32'd0);
    check("csrwr_flush", 32'(flush_req), 32'd0);
    tick();
    clear_mem();
    check("add_rf_we",  32'(rf_we),     32'd1);
    check("add_waddr",  32'(rf_waddr),  32'd3);
    check("add_wdata",  rf_wdata,       32'h0000_0055);
    check("add_csr_we", 32'(csr_we),    32'd0);
    check("add_flush",  32'(flush_req), 32'd0);
    tick();
    check("idle_rf_we", 32'(rf_we), 32'd0);

    // Reset while draining
    drive(32'h1C00_0500, 5'b00100, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0, 1'b0, 5'h0, 32'h0);
    tick();
    clear_mem();
    check("rd_flush", 32'(flush_req), 32'd1);
    tick();
    check("rd_in_drain", 32'(wb_allowin), 32'd0);
    resetn = 1'b0;
    drive(32'h1C00_0600, 5'b0, 32'h0, 1'b0, 1'b1, 14'h031, 32'h1, 1'b1, 5'd9, 32'h9);
    tick();
    resetn = 1'b1;
    clear_mem();
    check("rd_allowin", 32'(wb_allowin), 32'd1);
    check("rd_ex",      32'(wb_ex),      32'd0);
    check("rd_flushq",  32'(flush_req),  32'd0);
    check("rd_rf_we",   32'(rf_we),      32'd0);
    check("rd_csr_we",  32'(csr_we),     32'd0);
    check("rd_ertn",    32'(ertn_flush), 32'd0);
    tick();
    check("rd_still_run", 32'(wb_allowin), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_exc_commit.md
WB_EXC_COMMIT -- requirements
Module: wb_exc_commit

Interface
REQ-001 The block SHALL have parameter FLUSH_DRAIN, default 2, meaning the number of cycles MEM inputs are discarded after a flush (legal range 1..7).
REQ-002 The block SHALL have one clock; reset is synchronous and active-low.
REQ-003 Ports SHALL be:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- mem_valid  in  1  MEM presents an instruction
- mem_pc  in  32  its PC
- mem_exc  in  5  exception flags {ale, brk, sys, ine, adef}, bit0=adef
- mem_badv  in  32  faulting data address (ALE)
- mem_ertn  in  1  instruction is ertn
- mem_csr_we / mem_csr_num / mem_csr_wmask / mem_csr_wvalue  in  1/14/32/32  CSR write request
- mem_rf_we / mem_rf_waddr / mem_rf_wdata  in  1/5/32  GPR write request
- csr_has_int  in  1  pending enabled interrupt from the CSR file
- wb_allowin  out  1  WB accepts MEM this cycle
- wb_ex / wb_ecode / wb_esubcode  out  1/6/9  exception commit to CSR
- WB_pc / wb_badvaddr  out  32/32  committed PC, bad address
- ertn_flush  out  1  ertn commit
- csr_we / csr_num / csr_wmask / csr_wvalue  out  1/14/32/32  CSR write port
- rf_we / rf_waddr / rf_wdata  out  1/5/32  GPR write port
- flush_req / flush_sel  out  1/1  redirect front end; sel 0=ex_entry, 1=ex_exit

Function
REQ-004 The block SHALL hold one WB pipeline register (valid + all MEM fields), loaded when mem_valid & wb_allowin.
REQ-005 wb_allowin SHALL be 1 in RUN and 0 in DRAIN; WB never stalls otherwise.
REQ-006 An instruction is interrupt-tagged iff wb_valid & csr_has_int in its WB cycle (combinational sample).
REQ-007 Priority SHALL be INT > ADEF > INE > SYS > BRK > ALE; codes: INT 0x00, ADEF 0x08/esub 0, INE 0x0D, SYS 0x0B, BRK 0x0C, ALE 0x09; esubcode 0 for all.
REQ-008 wb_ex SHALL be 1 for exactly the WB cycle of a valid instruction with any tag; outputs are combinational from the WB register, zero latency.
REQ-009 wb_badvaddr SHALL be the WB PC for ADEF, the latched mem_badv for ALE, 0 otherwise.
REQ-010 When wb_ex=1, csr_we, rf_we and ertn_flush SHALL be 0 (side-effects suppressed).
REQ-011 ertn_flush SHALL be wb_valid & ertn & ~wb_ex; csr_we SHALL be wb_valid & csr_we & ~wb_ex; rf_we likewise.
REQ-012 flush_req SHALL equal wb_ex | ertn_flush; flush_sel = ertn_flush.
REQ-013 FSM states RUN, DRAIN: RUN->DRAIN on flush_req, loading counter with FLUSH_DRAIN; DRAIN decrements each cycle, ->RUN when counter reaches 1.
REQ-014 On flush_req the WB register valid SHALL clear at the next edge; MEM inputs in that edge and all DRAIN cycles are discarded.
REQ-015 An interrupt SHALL NOT be taken when wb_valid=0 (bubbles, DRAIN).
REQ-016 WB_pc SHALL reflect the register even when invalid; consumers qualify with wb_valid-derived strobes.

Reset
REQ-017 With resetn=0 at a clock edge: wb_valid=0, state=RUN, counter=0; hence wb_ex, ertn_flush, csr_we, rf_we, flush_req=0 and wb_allowin=1 the following cycle.
REQ-018 Reset SHALL override DRAIN and any in-flight instruction; data fields need no reset.

Configuration
REQ-019 Macro WB_TRACE_EN, when defined, SHALL add outputs debug_wb_pc (32), debug_wb_rf_we (4, replicated rf_we), debug_wb_rf_wnum (5), debug_wb_rf_wdata (32); when undefined these ports and logic SHALL be absent, with no other behavioural change.

Structure
REQ-020 A shared package SHALL hold ecode/esubcode constants, mem_exc bit indices and CSR number constants, reused by the CSR file.
REQ-021 The priority encoder SHALL be a sub-module exc_prio_enc (tags in, ex/ecode/esubcode/is_adef/is_ale out).

Verification
REQ-022 The bench SHALL cover:
- ADEF pc=0x1C00_0004: wb_ex=1, ecode=0x08, badv=0x1C00_0004, flush_sel=0.
- ALE with badv=0x0000_0123 and rf_we=1: ecode=0x09, badv=0x123, rf_we=0.
- SYS and BRK both set, csr_has_int=1: ecode=0x00.
- ertn: ertn_flush=1, flush_sel=1; the next FLUSH_DRAIN MEM instructions do not commit; wb_allowin=0 for exactly 2 cycles.
- Back-to-back csrwr to SAVE0 then add: csr_we, then rf_we, in consecutive cycles, no flush.
- resetn=0 during DRAIN: next cycle RUN, wb_allowin=1, no strobes.
